// File: rtl/embcpu_jtag_dbg_pkg.sv
// Shared types and constants for the Nios II OCI debug-port JTAG host.
package embcpu_jtag_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SHIFT,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } dbg_state_e;

  localparam int DEFAULT_IR_WIDTH = 2;
  localparam int DEFAULT_DR_WIDTH = 38;

  // OCI instruction codes understood by the debug module's TCK-side logic
  localparam logic [1:0] OCI_IR_OCIMEM    = 2'b00;
  localparam logic [1:0] OCI_IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] OCI_IR_BREAK     = 2'b10;
  localparam logic [1:0] OCI_IR_TRACECTRL = 2'b11;

endpackage

// File: rtl/embcpu_jtag_dbg_tck_gen.sv
// Test-clock generator: tck is low for the first TCK_HALF clk cycles of each
// period and high for the rest; pulses flag the cycle before the rise and period end.
module embcpu_jtag_dbg_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tck,
  output logic tck_rise,
  output logic period_end
);

  localparam int            CW        = $clog2(2 * TCK_HALF + 1);
  localparam logic [CW-1:0] RISE_AT   = CW'(TCK_HALF - 1);
  localparam logic [CW-1:0] LAST      = CW'(2 * TCK_HALF - 1);
  localparam logic [CW-1:0] HIGH_FROM = CW'(TCK_HALF);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // Clearing parks the counter at the start of a period so the first phase
  // after a clear begins with a full low half.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= cnt_next;
      tck <= (cnt_next >= HIGH_FROM);
    end
  end

  assign tck_rise   = !clear && (cnt == RISE_AT);
  assign period_end = !clear && (cnt == LAST);

endmodule

// File: rtl/embcpu_nios2_qsys_0_jtag_debug_host.sv
// Bit-serial host for the Nios II OCI virtual-JTAG port: takes one scan command,
// walks UIR/CDR/SHIFT/UDR/RTI on a generated tck and returns the captured tdo bits.
module embcpu_nios2_qsys_0_jtag_debug_host
  import embcpu_jtag_dbg_pkg::*;
#(
  parameter int IR_WIDTH    = DEFAULT_IR_WIDTH,
  parameter int DR_WIDTH    = DEFAULT_DR_WIDTH,
  parameter int TCK_HALF    = 2,
  parameter int RTI_PERIODS = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo
);

  localparam int               CNT_MAX    = (DR_WIDTH > RTI_PERIODS) ? DR_WIDTH : RTI_PERIODS;
  localparam int               CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DR_WIDTH - 1);
  localparam logic [CNT_W-1:0] RTI_LAST   = CNT_W'(RTI_PERIODS - 1);

  dbg_state_e          state, state_n;
  logic                pending, pending_n;
  logic                ir_valid, ir_valid_n;
  logic [IR_WIDTH-1:0] ir_q, ir_q_n, ir_in_n;
  logic [DR_WIDTH-1:0] data_sr, data_sr_n, cap_n;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic                tdi_n;
  logic                tck_clear, tck_rise, period_end;

  assign tck_clear = (state == ST_IDLE) || (state == ST_RESP);

  embcpu_jtag_dbg_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (tck_clear),
    .tck        (vji_tck),
    .tck_rise   (tck_rise),
    .period_end (period_end)
  );

  // The accepted command waits one cycle in IDLE (pending) so the first phase
  // starts on a clean tck period; rsp_data doubles as the capture register.
  always_comb begin
    state_n    = state;
    pending_n  = pending;
    ir_valid_n = ir_valid;
    ir_q_n     = ir_q;
    ir_in_n    = vji_ir_in;
    data_sr_n  = data_sr;
    cap_n      = rsp_data;
    bit_cnt_n  = bit_cnt;
    tdi_n      = vji_tdi;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          pending_n = 1'b0;
          if (!ir_valid || (ir_q != vji_ir_in)) begin
            state_n    = ST_UIR;
            ir_in_n    = ir_q;
            ir_valid_n = 1'b1;
          end else begin
            state_n = ST_CDR;
          end
        end else if (cmd_valid) begin
          pending_n = 1'b1;
          ir_q_n    = cmd_ir;
          data_sr_n = cmd_data;
        end
      end
      ST_UIR: if (period_end) state_n = ST_CDR;
      ST_CDR: begin
        if (period_end) begin
          state_n   = ST_SHIFT;
          bit_cnt_n = '0;
          tdi_n     = data_sr[0];
          data_sr_n = data_sr >> 1;
        end
      end
      ST_SHIFT: begin
        if (tck_rise) cap_n = {vji_tdo, rsp_data[DR_WIDTH-1:1]};
        if (period_end) begin
          if (bit_cnt == SHIFT_LAST) begin
            state_n = ST_UDR;
            tdi_n   = 1'b0;
          end else begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
            tdi_n     = data_sr[0];
            data_sr_n = data_sr >> 1;
          end
        end
      end
      ST_UDR: begin
        if (period_end) begin
          state_n   = ST_RTI;
          bit_cnt_n = '0;
        end
      end
      ST_RTI: begin
        if (period_end) begin
          if (bit_cnt == RTI_LAST) state_n = ST_RESP;
          else bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      ST_RESP: if (rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so strobes line up with tck periods.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      pending   <= 1'b0;
      ir_valid  <= 1'b0;
      ir_q      <= '0;
      data_sr   <= '0;
      bit_cnt   <= '0;
      rsp_data  <= '0;
      vji_ir_in <= '0;
      vji_tdi   <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      vji_uir   <= 1'b0;
      vji_cdr   <= 1'b0;
      vji_sdr   <= 1'b0;
      vji_udr   <= 1'b0;
      vji_rti   <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      ir_valid  <= ir_valid_n;
      ir_q      <= ir_q_n;
      data_sr   <= data_sr_n;
      bit_cnt   <= bit_cnt_n;
      rsp_data  <= cap_n;
      vji_ir_in <= ir_in_n;
      vji_tdi   <= tdi_n;
      cmd_ready <= (state_n == ST_IDLE) && !pending_n;
      rsp_valid <= (state_n == ST_RESP);
      vji_uir   <= (state_n == ST_UIR);
      vji_cdr   <= (state_n == ST_CDR);
      vji_sdr   <= (state_n == ST_SHIFT);
      vji_udr   <= (state_n == ST_UDR);
      vji_rti   <= (state_n == ST_RTI);
    end
  end

endmodule
